// File: rtl/dm_access_unit.sv
// dm_access_unit: load/store initiator for the word-addressed data memory.
// Handles byte/half/word accesses, alignment and range checks, and
// read-modify-write for sub-word stores, since the memory only writes whole words.
module dm_access_unit #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rd
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  lane_q, lane_d;
    // Only the low half of the store data is ever merged; word stores
    // go straight from the request into mem_wd at accept.
    logic [15:0] wdata_q, wdata_d;

    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_pc_q, mem_pc_d;

    logic        req_err;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_a      = mem_a_q;
    assign mem_wd     = mem_wd_q;
    assign mem_we     = mem_we_q;
    assign mem_pc     = mem_pc_q;

    // Request legality: illegal size, misalignment, or beyond the memory.
    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)                             req_err = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])            req_err = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
        if (req_addr >= MEM_LIMIT)                         req_err = 1'b1;
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        load_ext = mem_rd;
        case (size_q)
            SZ_BYTE: begin
                logic [7:0] b;
                case (lane_q)
                    2'd0:    b = mem_rd[7:0];
                    2'd1:    b = mem_rd[15:8];
                    2'd2:    b = mem_rd[23:16];
                    default: b = mem_rd[31:24];
                endcase
                load_ext = {{24{sgn_q & b[7]}}, b};
            end
            SZ_HALF: begin
                logic [15:0] h;
                h = lane_q[1] ? mem_rd[31:16] : mem_rd[15:0];
                load_ext = {{16{sgn_q & h[15]}}, h};
            end
            default: load_ext = mem_rd;
        endcase
    end

    // Replace only the addressed lane(s) of the old word for sub-word stores.
    always_comb begin
        merged = mem_rd;
        if (size_q == SZ_BYTE) begin
            case (lane_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    // Next-state and output-register logic for the access FSM.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_a_d      = mem_a_q;
        mem_wd_d     = mem_wd_q;
        mem_we_d     = 1'b0;
        mem_pc_d     = mem_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata[15:0];
                    if (req_err) begin
                        // Faulting requests never touch the memory port.
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else begin
                        mem_a_d  = {req_addr[31:2], 2'b00};
                        mem_pc_d = req_pc;
                        if (req_we && req_size == SZ_WORD) begin
                            state_d  = ST_WRITE;
                            mem_wd_d = req_wdata;
                            mem_we_d = 1'b1;
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_READ: begin
                if (we_q) begin
                    state_d  = ST_WRITE;
                    mem_wd_d = merged;
                    mem_we_d = 1'b1;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = load_ext;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'd0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            sgn_q        <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 16'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            mem_a_q      <= 32'd0;
            mem_wd_q     <= 32'd0;
            mem_we_q     <= 1'b0;
            mem_pc_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_a_q      <= mem_a_d;
            mem_wd_q     <= mem_wd_d;
            mem_we_q     <= mem_we_d;
            mem_pc_q     <= mem_pc_d;
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: word memory model plus directed vectors.
module tb_dm_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_pc;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:1023];

    int n_chk = 0;
    int n_err = 0;
    int we_cnt = 0;
    int acc_cnt = 0;
    int resp_cnt = 0;
    logic [31:0] last_wa;
    logic [31:0] last_wd;

    dm_access_unit #(.MEM_BYTES(4096)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_pc(mem_pc),
        .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[11:2]];

    // Memory write port and event counters.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[11:2]] <= mem_wd;
            we_cnt  <= we_cnt + 1;
            last_wa <= mem_a;
            last_wd <= mem_wd;
        end
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, then check latency, response and write count.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd, input logic exp_e,
                          input int exp_writes);
        int lat;
        int w0;
        @(negedge clk);
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        w0 = we_cnt;
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wd; req_pc = addr + 32'h1000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".rdata"}, resp_rdata, exp_rd);
        check({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_e});
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, {31'd0, resp_valid}, 32'd0);
        check({tag, ".writes"}, we_cnt - w0, exp_writes);
    endtask

    initial begin
        int a0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_pc = 32'd0;
        #12;
        check("rst.ready", {31'd0, req_ready}, 32'd1);
        check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst.mem_we", {31'd0, mem_we}, 32'd0);
        check("rst.mem_a", mem_a, 32'd0);
        check("rst.mem_wd", mem_wd, 32'd0);
        check("rst.mem_pc", mem_pc, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Word store then load.
        do_req("sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'd0, 1'b0, 1);
        check("sw.addr", last_wa, 32'h10);
        check("sw.data", last_wd, 32'hDEADBEEF);
        check("sw.pc", mem_pc, 32'h1010);
        do_req("lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 2, 32'hDEADBEEF, 1'b0, 0);

        // Sub-word read-modify-write.
        mem[32'h20 >> 2] = 32'h11223344;
        do_req("sb", 1'b1, 2'b00, 1'b0, 32'h22, 32'hFFFFFFAA, 3, 32'd0, 1'b0, 1);
        check("sb.addr", last_wa, 32'h20);
        check("sb.data", last_wd, 32'h11AA3344);
        do_req("sh", 1'b1, 2'b01, 1'b0, 32'h20, 32'h0000BEEF, 3, 32'd0, 1'b0, 1);
        check("sh.data", last_wd, 32'h11AABEEF);

        // Load extension.
        mem[32'h30 >> 2] = 32'h80FF7F01;
        do_req("lb",  1'b0, 2'b00, 1'b1, 32'h33, 32'd0, 2, 32'hFFFFFF80, 1'b0, 0);
        do_req("lbu", 1'b0, 2'b00, 1'b0, 32'h33, 32'd0, 2, 32'h00000080, 1'b0, 0);
        do_req("lh",  1'b0, 2'b01, 1'b1, 32'h32, 32'd0, 2, 32'hFFFF80FF, 1'b0, 0);
        do_req("lhu", 1'b0, 2'b01, 1'b0, 32'h30, 32'd0, 2, 32'h00007F01, 1'b0, 0);
        do_req("lb0", 1'b0, 2'b00, 1'b1, 32'h30, 32'd0, 2, 32'h00000001, 1'b0, 0);

        // Error cases.
        do_req("e.sh21",  1'b1, 2'b01, 1'b0, 32'h21,   32'h1234, 1, 32'd0, 1'b1, 0);
        do_req("e.lw2",   1'b0, 2'b10, 1'b0, 32'h2,    32'd0,    1, 32'd0, 1'b1, 0);
        do_req("e.sz3",   1'b0, 2'b11, 1'b0, 32'h0,    32'd0,    1, 32'd0, 1'b1, 0);
        do_req("e.sw1k",  1'b1, 2'b10, 1'b0, 32'h1000, 32'h5A5A, 1, 32'd0, 1'b1, 0);
        check("e.mem0", mem[0], 32'd0);
        do_req("lw_last", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'd0, 2, 32'd0, 1'b0, 0);

        // Handshake: valid held high, request altered mid-operation.
        @(negedge clk);
        a0 = acc_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h12345678; req_pc = 32'h0;
        @(posedge clk); #1;
        req_addr = 32'h44; req_wdata = 32'hCAFEF00D;
        check("hs.ready_wr", {31'd0, req_ready}, 32'd0);
        check("hs.wd", mem_wd, 32'h12345678);
        @(posedge clk); #1;
        check("hs.ready_resp", {31'd0, req_ready}, 32'd0);
        check("hs.wd_resp", mem_wd, 32'h12345678);
        @(posedge clk); #1;
        check("hs.ready_idle", {31'd0, req_ready}, 32'd1);
        check("hs.acc1", acc_cnt - a0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("hs.acc2", acc_cnt - a0, 2);
        repeat (3) @(posedge clk);
        #1;
        check("hs.m40", mem[32'h40 >> 2], 32'h12345678);
        check("hs.m44", mem[32'h44 >> 2], 32'hCAFEF00D);

        // Reset abort during READ of a byte store.
        mem[32'h50 >> 2] = 32'h55555555;
        @(negedge clk);
        a0 = we_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00;
        req_addr = 32'h51; req_wdata = 32'h000000EE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("ra.in_read", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("ra.mem_we", {31'd0, mem_we}, 32'd0);
        check("ra.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("ra.ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        a0 = resp_cnt - 0 + (we_cnt - a0) * 1000;
        repeat (4) @(posedge clk);
        #1;
        check("ra.ready_after", {31'd0, req_ready}, 32'd1);
        check("ra.nowrite_resp", resp_cnt + (we_cnt - (we_cnt - 0)) * 0, a0);
        check("ra.mem", mem[32'h50 >> 2], 32'h55555555);
        check("ra.resp_valid_after", {31'd0, resp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Watchdog so a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- Initiator-side load/store unit that drives the word-addressed data memory on behalf of the pipeline's MEM stage.
- Accepts byte, half and word load/store requests over a valid/ready handshake.
- Checks alignment and range, and issues word-wide reads and writes to the memory.
- Performs read-modify-write for sub-word stores, because the memory only writes whole words; returns sign- or zero-extended load data.

Parameters:
- MEM_BYTES, 4096, addressable memory size in bytes (1024 words); any request with addr >= MEM_BYTES is an error.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_pc  in  32  PC of the issuing instruction, forwarded to memory for trace
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal size; valid with resp_valid
- mem_a  out  32  word address {addr[31:2],2'b00}
- mem_wd  out  32  full word to write
- mem_we  out  1  memory write enable
- mem_pc  out  32  latched req_pc
- mem_rd  in  32  combinational read data for mem_a

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Reset (async, reset=0): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_a=0, mem_wd=0, mem_pc=0.
  - req_ready = (state==IDLE), so it reads 1 during reset.
- Accept: req_valid & req_ready at a rising edge.
  - Latch we, size, signed, addr, wdata and pc.
  - Inputs are ignored outside IDLE.
- Error check at accept: error if any of the following holds:
  - size==11
  - size==01 & addr[0]
  - size==10 & addr[1:0]!=0
  - addr>=MEM_BYTES
- Error path: IDLE->RESP, resp_err=1, no memory write.
- Load: IDLE->READ->RESP.
  - In READ, mem_a is driven and mem_rd is captured at the end of the cycle.
  - Little-endian lanes: byte k = mem_rd[8k+7:8k], k = addr[1:0]; half = mem_rd[16*addr[1]+15 : 16*addr[1]].
  - Extended to 32 bits per req_signed.
- Store word: IDLE->WRITE->RESP. In WRITE, mem_we=1 and mem_wd=wdata.
- Store byte/half: IDLE->READ->WRITE->RESP.
  - READ captures the old word.
  - WRITE drives the old word with only the addressed lane(s) replaced.
- mem_we is high for exactly one cycle per successful store and is never high in any state other than WRITE.
- RESP: resp_valid=1 for one cycle, with resp_rdata and resp_err held. Next state is IDLE.
  - A new request can be accepted on the edge that leaves RESP only if it is already IDLE, so back-to-back throughput is 1 request per (latency+1) cycles.
- Latency, accept edge to resp_valid: error 1 cycle, load 2, word store 2, sub-word store 3.
- Reset mid-operation: immediately return to IDLE and drop mem_we.
  - A store interrupted in READ performs no write.
  - No response is issued for the aborted request.
- mem_a, mem_wd and mem_pc hold their values outside READ/WRITE.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF.
  - Expect exactly one cycle of mem_we=1 with mem_a=0x10, mem_wd=0xDEADBEEF.
  - Load word 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after accept.
- Sub-word RMW: memory word 0x20 = 0x11223344; store byte 0xAA at 0x22.
  - Expect mem_wd=0x11AA3344.
  - Store half 0xBEEF at 0x20 -> mem_wd=0x11AABEEF.
  - resp_valid 3 cycles after accept.
- Load extension: word 0x30 = 0x80FF7F01.
  - lb 0x33 signed -> 0xFFFFFF80.
  - lbu 0x33 -> 0x00000080.
  - lh 0x32 signed -> 0xFFFF80FF.
  - lhu 0x30 -> 0x00007F01.
- Errors: each of the following gives resp_err=1 one cycle after accept, mem_we never asserted, rdata=0:
  - half store at 0x21
  - word load at 0x2
  - size=11
  - word store at 0x1000
- Handshake: hold req_valid high continuously.
  - req_ready is low in READ/WRITE/RESP and only one request is accepted per IDLE visit.
  - Requests changed mid-operation do not alter mem_wd.
- Reset abort: assert reset low during READ of a byte store.
  - mem_we=0, no write to memory, resp_valid=0, state IDLE, req_ready=1 after release.
